// File: rtl/ctrl_pipe_if.sv
// Shared ALU op type plus the fetch->decode->execute control bundle interface.
// No logic here: pure signal grouping, so no latency of its own.
// Backpressure is carried by instr_ready; the execute side cannot stall the bundle.
package ctrl_pipe_pkg;
    // ALU operation mnemonics driven on ALU_OP
    typedef enum logic [3:0] {
        NOP    = 4'd0,
        ADD    = 4'd1,
        SUB    = 4'd2,
        ORR    = 4'd3,
        AND    = 4'd4,
        XOR    = 4'd5,
        LSH    = 4'd6,
        INC    = 4'd7,
        DEC    = 4'd8,
        CLR    = 4'd9,
        RXOR_7 = 4'd10,
        RXOR_8 = 4'd11
    } op_mne;
endpackage

interface ctrl_pipe_if #(
    parameter int W = 8
);
    import ctrl_pipe_pkg::*;

    // fetch side
    logic         instr_valid;
    logic         instr_ready;
    logic [8:0]   Instruction;
    logic         flush;

    // execute side
    logic         ctrl_valid;
    op_mne        ALU_OP;
    logic [W-1:0] Imm;
    logic         ImmSelA;
    logic [3:0]   RaddrA;
    logic [3:0]   RaddrB;
    logic [3:0]   Waddr;
    logic         RegWrite;
    logic [1:0]   RegSrc;
    logic         BranchEZ;
    logic         BranchNZ;
    logic         BranchAlways;
    logic         read_mem;
    logic         write_mem;
    logic         Done;

    // driven by fetch/execute environment
    modport master (
        output instr_valid, Instruction, flush,
        input  instr_ready, ctrl_valid, ALU_OP, Imm, ImmSelA, RaddrA, RaddrB, Waddr,
               RegWrite, RegSrc, BranchEZ, BranchNZ, BranchAlways, read_mem, write_mem, Done
    );

    // the decoder
    modport slave (
        input  instr_valid, Instruction, flush,
        output instr_ready, ctrl_valid, ALU_OP, Imm, ImmSelA, RaddrA, RaddrB, Waddr,
               RegWrite, RegSrc, BranchEZ, BranchNZ, BranchAlways, read_mem, write_mem, Done
    );
endinterface

// File: rtl/ctrl_pipe.sv
// Registered, stall-aware instruction decoder producing the execute-stage control bundle.
// Latency: 1 cycle from acceptance (instr_valid & instr_ready) to ctrl_valid.
// Backpressure: instr_ready drops during load wait, halt and flush; ctrl_valid is never held back.
module ctrl_pipe
    import ctrl_pipe_pkg::*;
#(
    parameter int W        = 8,
    parameter int T        = 10,
    parameter int MEM_LAT  = 2,
    parameter int LINK_REG = 14
) (
    input  logic        Clk,
    input  logic        Reset,
    ctrl_pipe_if.slave  cp
);

    // Reject illegal parameterisations at elaboration time
    if (W < 8 || T < 1 || MEM_LAT < 1 || LINK_REG < 0 || LINK_REG > 15) begin : g_bad_param
        $error("ctrl_pipe: illegal parameter set");
    end

    // Opcode field I[7:4] when I[8]=0. Paired opcodes are split by I[3] (0 = first name).
    localparam logic [3:0] OPC_PUT     = 4'h0;
    localparam logic [3:0] OPC_GET     = 4'h1;
    localparam logic [3:0] OPC_LDW_STW = 4'h2;
    localparam logic [3:0] OPC_NXT_CLB = 4'h3;
    localparam logic [3:0] OPC_ADD     = 4'h4;
    localparam logic [3:0] OPC_SUB     = 4'h5;
    localparam logic [3:0] OPC_ORR     = 4'h6;
    localparam logic [3:0] OPC_AND     = 4'h7;
    localparam logic [3:0] OPC_LSH_PTY = 4'h8;
    localparam logic [3:0] OPC_XOR     = 4'h9;
    localparam logic [3:0] OPC_CHK     = 4'hA;
    localparam logic [3:0] OPC_DNE     = 4'hB;
    localparam logic [3:0] OPC_JNZ_JEZ = 4'hE;
    localparam logic [3:0] OPC_JMP_JAL = 4'hF;

    localparam logic [1:0] ST_RUN       = 2'd0;
    localparam logic [1:0] ST_LOAD_WAIT = 2'd1;
    localparam logic [1:0] ST_HALT      = 2'd2;

    localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    typedef struct packed {
        op_mne        alu_op;
        logic [W-1:0] imm;
        logic         imm_sel_a;
        logic [3:0]   raddr_a;
        logic [3:0]   raddr_b;
        logic [3:0]   waddr;
        logic         reg_write;
        logic [1:0]   reg_src;
        logic         br_ez;
        logic         br_nz;
        logic         br_al;
        logic         rd_mem;
        logic         wr_mem;
    } bundle_t;

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic          vld_q;
    logic          done_q;
    bundle_t       bnd_q;
    bundle_t       dec;
    logic          dec_ldw;
    logic          dec_dne;
    logic          accept;

    logic [8:0] ins;
    logic [3:0] opc;
    logic       sub;
    logic [3:0] s_reg;
    logic [3:0] g_reg;

    assign ins   = cp.Instruction;
    assign opc   = ins[7:4];
    assign sub   = ins[3];
    assign s_reg = {1'b1, ins[2:0]};
    assign g_reg = {1'b0, ins[2:0]};

    // Only RUN takes instructions, and a flush kills whatever is presented alongside it
    assign cp.instr_ready = (state == ST_RUN) && !cp.flush;
    assign accept         = cp.instr_valid && cp.instr_ready;

    // Combinational decode of the presented instruction into a candidate bundle
    always_comb begin
        dec           = '0;
        dec.alu_op    = NOP;
        dec.reg_write = 1'b1;
        dec_ldw       = 1'b0;
        dec_dne       = 1'b0;
        if (ins[8]) begin
            dec.imm       = W'(ins[7:0]);
            dec.imm_sel_a = 1'b1;
        end else begin
            case (opc)
                OPC_PUT: dec.waddr   = ins[3:0];
                OPC_GET: dec.raddr_a = ins[3:0];
                OPC_LDW_STW: begin
                    dec.raddr_a = s_reg;
                    if (!sub) begin
                        dec.reg_src = 2'd1;
                        dec.rd_mem  = 1'b1;
                        dec_ldw     = 1'b1;
                    end else begin
                        dec.reg_write = 1'b0;
                        dec.wr_mem    = 1'b1;
                    end
                end
                OPC_NXT_CLB: begin
                    if (!sub) begin
                        dec.raddr_a = s_reg;
                        dec.waddr   = s_reg;
                        if (s_reg <= 4'd10)      dec.alu_op = INC;
                        else if (s_reg <= 4'd13) dec.alu_op = DEC;
                        else                     dec.alu_op = NOP;
                    end else begin
                        dec.raddr_a = g_reg;
                        dec.waddr   = g_reg;
                        dec.alu_op  = CLR;
                    end
                end
                OPC_ADD: begin dec.alu_op = ADD; dec.raddr_b = ins[3:0]; end
                OPC_SUB: begin dec.alu_op = SUB; dec.raddr_b = ins[3:0]; end
                OPC_ORR: begin dec.alu_op = ORR; dec.raddr_b = ins[3:0]; end
                OPC_AND: begin dec.alu_op = AND; dec.raddr_b = ins[3:0]; end
                OPC_XOR: begin dec.alu_op = XOR; dec.raddr_b = ins[3:0]; end
                OPC_LSH_PTY: begin
                    if (!sub) begin
                        dec.alu_op    = LSH;
                        dec.imm       = W'(ins[2:0]);
                        dec.imm_sel_a = 1'b1;
                    end else begin
                        dec.alu_op  = RXOR_7;
                        dec.raddr_a = g_reg;
                    end
                end
                OPC_CHK: begin dec.alu_op = RXOR_8; dec.raddr_a = ins[3:0]; end
                OPC_DNE: begin dec.reg_write = 1'b0; dec_dne = 1'b1; end
                OPC_JNZ_JEZ: begin
                    dec.reg_write = 1'b0;
                    dec.raddr_a   = g_reg;
                    dec.br_nz     = !sub;
                    dec.br_ez     = sub;
                end
                OPC_JMP_JAL: begin
                    dec.raddr_a = g_reg;
                    dec.br_al   = 1'b1;
                    if (sub) begin
                        dec.waddr   = 4'(LINK_REG);
                        dec.reg_src = 2'd2;
                    end else begin
                        dec.reg_write = 1'b0;
                    end
                end
                default: dec.reg_write = 1'b0;   // undefined opcodes
            endcase
        end
    end

    // Control FSM, load-wait counter and the registered bundle
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state  <= ST_RUN;
            cnt    <= '0;
            vld_q  <= 1'b0;
            done_q <= 1'b0;
            bnd_q  <= '0;
        end else begin
            case (state)
                ST_HALT: vld_q <= 1'b0;
                ST_LOAD_WAIT: begin
                    vld_q <= 1'b0;
                    if (cp.flush || cnt == CW'(1)) begin
                        state <= ST_RUN;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: begin
                    if (accept && dec_dne) begin
                        // DNE carries no execute-stage work; it only halts
                        state  <= ST_HALT;
                        done_q <= 1'b1;
                        vld_q  <= 1'b0;
                    end else if (accept) begin
                        bnd_q <= dec;
                        vld_q <= 1'b1;
                        if (dec_ldw && MEM_LAT > 1) begin
                            state <= ST_LOAD_WAIT;
                            cnt   <= CW'(MEM_LAT - 1);
                        end
                    end else begin
                        vld_q <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign cp.ctrl_valid   = vld_q;
    assign cp.Done         = done_q;
    assign cp.ALU_OP       = bnd_q.alu_op;
    assign cp.Imm          = bnd_q.imm;
    assign cp.ImmSelA      = bnd_q.imm_sel_a;
    assign cp.RaddrA       = bnd_q.raddr_a;
    assign cp.RaddrB       = bnd_q.raddr_b;
    assign cp.Waddr        = bnd_q.waddr;
    assign cp.RegSrc       = bnd_q.reg_src;
    // Side-effecting strobes only ever fire alongside a live bundle
    assign cp.RegWrite     = bnd_q.reg_write & vld_q;
    assign cp.read_mem     = bnd_q.rd_mem    & vld_q;
    assign cp.write_mem    = bnd_q.wr_mem    & vld_q;
    assign cp.BranchEZ     = bnd_q.br_ez     & vld_q;
    assign cp.BranchNZ     = bnd_q.br_nz     & vld_q;
    assign cp.BranchAlways = bnd_q.br_al     & vld_q;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Self-checking bench for ctrl_pipe: directed plan items plus randomized traffic.
// Expected bundles are queued at issue time and popped by an independent monitor.
// The reference model tracks only stall length, halt and the ISA decode table.
module tb_ctrl_pipe;
    import ctrl_pipe_pkg::*;

    localparam int W       = 8;
    localparam int MEM_LAT = 2;
    localparam int LINK    = 14;

    typedef struct packed {
        op_mne      alu;
        logic [7:0] imm;
        logic       isa;
        logic [3:0] ra;
        logic [3:0] rb;
        logic [3:0] wa;
        logic       rw;
        logic [1:0] rs;
        logic       bez;
        logic       bnz;
        logic       bal;
        logic       rd;
        logic       wr;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   errors;
    bit   mon_en;
    bit   exp_ready;
    bit   m_halt;
    int   m_stall;
    int   done_cyc;
    exp_t e_q[$];
    int   c_q[$];

    ctrl_pipe_if #(.W(W)) bus ();

    ctrl_pipe #(.W(W), .T(10), .MEM_LAT(MEM_LAT), .LINK_REG(LINK)) dut (
        .Clk   (clk),
        .Reset (rst),
        .cp    (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    // ISA table: what the execute stage must see for one instruction
    function automatic exp_t model(input logic [8:0] i);
        exp_t e;
        logic [3:0] s;
        logic [3:0] g;
        s = {1'b1, i[2:0]};
        g = {1'b0, i[2:0]};
        e = '0;
        e.alu = NOP;
        e.rw  = 1'b1;
        if (i[8]) begin
            e.imm = i[7:0];
            e.isa = 1'b1;
        end else begin
            case (i[7:4])
                4'h0: e.wa = i[3:0];
                4'h1: e.ra = i[3:0];
                4'h2: begin
                    e.ra = s;
                    if (i[3]) begin e.rw = 1'b0; e.wr = 1'b1; end
                    else      begin e.rs = 2'd1; e.rd = 1'b1; end
                end
                4'h3: begin
                    if (i[3]) begin e.ra = g; e.wa = g; e.alu = CLR; end
                    else begin
                        e.ra = s;
                        e.wa = s;
                        e.alu = (s < 11) ? INC : (s < 14) ? DEC : NOP;
                    end
                end
                4'h4: begin e.alu = ADD; e.rb = i[3:0]; end
                4'h5: begin e.alu = SUB; e.rb = i[3:0]; end
                4'h6: begin e.alu = ORR; e.rb = i[3:0]; end
                4'h7: begin e.alu = AND; e.rb = i[3:0]; end
                4'h9: begin e.alu = XOR; e.rb = i[3:0]; end
                4'h8: begin
                    if (i[3]) begin e.alu = RXOR_7; e.ra = g; end
                    else begin e.alu = LSH; e.imm = {5'd0, i[2:0]}; e.isa = 1'b1; end
                end
                4'hA: begin e.alu = RXOR_8; e.ra = i[3:0]; end
                4'hE: begin
                    e.rw = 1'b0;
                    e.ra = g;
                    if (i[3]) e.bez = 1'b1; else e.bnz = 1'b1;
                end
                4'hF: begin
                    e.ra  = g;
                    e.bal = 1'b1;
                    if (i[3]) begin e.wa = 4'(LINK); e.rs = 2'd2; end
                    else e.rw = 1'b0;
                end
                default: e.rw = 1'b0;
            endcase
        end
        return e;
    endfunction

    function automatic exp_t sample();
        exp_t a;
        a.alu = bus.ALU_OP;
        a.imm = bus.Imm;
        a.isa = bus.ImmSelA;
        a.ra  = bus.RaddrA;
        a.rb  = bus.RaddrB;
        a.wa  = bus.Waddr;
        a.rw  = bus.RegWrite;
        a.rs  = bus.RegSrc;
        a.bez = bus.BranchEZ;
        a.bnz = bus.BranchNZ;
        a.bal = bus.BranchAlways;
        a.rd  = bus.read_mem;
        a.wr  = bus.write_mem;
        return a;
    endfunction

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    // Drive one cycle of fetch traffic and advance the reference model
    task automatic step(input logic v, input logic [8:0] i, input logic f);
        bit rdy;
        rdy = !m_halt && (m_stall == 0) && !f;
        bus.instr_valid = v;
        bus.Instruction = i;
        bus.flush       = f;
        exp_ready       = rdy;
        if (v && rdy) begin
            if (i[8:4] == 5'b0_1011) begin
                m_halt   = 1'b1;
                done_cyc = cyc + 1;
            end else begin
                e_q.push_back(model(i));
                c_q.push_back(cyc + 1);
            end
            if (i[8:4] == 5'b0_0010 && !i[3]) m_stall = MEM_LAT - 1;
        end else if (f) begin
            m_stall = 0;
        end else if (m_stall > 0) begin
            m_stall--;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        exp_t z;
        z = '0;
        z.alu = NOP;
        rst = 1'b1;
        bus.instr_valid = 1'b0;
        bus.Instruction = '0;
        bus.flush       = 1'b0;
        e_q.delete();
        c_q.delete();
        m_stall  = 0;
        m_halt   = 1'b0;
        done_cyc = 0;
        #1;
        chk("reset_bundle", 32'(sample()), 32'(z));
        chk("reset_ctrl_valid", 32'(bus.ctrl_valid), 32'd0);
        chk("reset_done", 32'(bus.Done), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_ready = 1'b1;
    endtask

    // Monitor: handshake, Done, strobe gating and bundle scoreboard every cycle
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            checks++;
            if (bus.instr_ready !== exp_ready) begin
                errors++;
                $display("FAIL instr_ready cyc=%0d: got %b expected %b", cyc, bus.instr_ready, exp_ready);
            end
            checks++;
            if (bus.Done !== (m_halt && cyc >= done_cyc)) begin
                errors++;
                $display("FAIL done cyc=%0d: got %b expected %b", cyc, bus.Done, m_halt && cyc >= done_cyc);
            end
            if (bus.ctrl_valid === 1'b1) begin
                checks++;
                if (e_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_bundle cyc=%0d: got ctrl_valid=1 expected no bundle", cyc);
                end else begin
                    exp_t e;
                    exp_t a;
                    int   c;
                    e = e_q.pop_front();
                    c = c_q.pop_front();
                    a = sample();
                    if (c != cyc) begin
                        errors++;
                        $display("FAIL bundle_latency: got cycle %0d expected cycle %0d", cyc, c);
                    end
                    checks++;
                    if (a !== e) begin
                        errors++;
                        $display("FAIL bundle cyc=%0d: got %h expected %h", cyc, a, e);
                    end
                end
            end else begin
                checks++;
                if ({bus.RegWrite, bus.read_mem, bus.write_mem, bus.BranchEZ, bus.BranchNZ,
                     bus.BranchAlways} !== 6'b0) begin
                    errors++;
                    $display("FAIL strobe_gating cyc=%0d: got strobes set expected 0", cyc);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [8:0] ri;
        cyc = 0; checks = 0; errors = 0; mon_en = 1'b0;
        exp_ready = 1'b1; m_halt = 1'b0; m_stall = 0; done_cyc = 0;
        rst = 1'b1;
        do_reset();
        mon_en = 1'b1;

        // ADD r5 single cycle, then idle
        step(1'b1, 9'b0_0100_0101, 1'b0);
        chk("add_valid", 32'(bus.ctrl_valid), 32'd1);
        chk("add_op", 32'(bus.ALU_OP), 32'(ADD));
        chk("add_rb", 32'(bus.RaddrB), 32'd5);
        chk("add_rw", 32'(bus.RegWrite), 32'd1);
        step(1'b0, 9'b0_0100_0101, 1'b0);
        chk("idle_valid", 32'(bus.ctrl_valid), 32'd0);
        chk("idle_rw", 32'(bus.RegWrite), 32'd0);

        // immediates
        step(1'b1, 9'b1_1010_0111, 1'b0);
        chk("ldi_imm", 32'(bus.Imm), 32'hA7);
        chk("ldi_isa", 32'(bus.ImmSelA), 32'd1);
        chk("ldi_op", 32'(bus.ALU_OP), 32'(NOP));
        step(1'b1, 9'b0_1000_0101, 1'b0);
        chk("lsh_imm", 32'(bus.Imm), 32'd5);
        chk("lsh_op", 32'(bus.ALU_OP), 32'(LSH));

        // LDW stall, GET held valid
        step(1'b1, 9'b0_0010_0011, 1'b0);
        chk("ldw_ra", 32'(bus.RaddrA), 32'd11);
        chk("ldw_rd", 32'(bus.read_mem), 32'd1);
        chk("ldw_src", 32'(bus.RegSrc), 32'd1);
        chk("ldw_stall", 32'(bus.instr_ready), 32'd0);
        step(1'b1, 9'b0_0001_0001, 1'b0);
        chk("ldw_resume", 32'(bus.instr_ready), 32'd1);
        step(1'b1, 9'b0_0001_0001, 1'b0);
        chk("get_valid", 32'(bus.ctrl_valid), 32'd1);
        chk("get_ra", 32'(bus.RaddrA), 32'd1);

        // JAL and NXT
        step(1'b1, 9'b0_1111_1010, 1'b0);
        chk("jal_wa", 32'(bus.Waddr), 32'd14);
        chk("jal_src", 32'(bus.RegSrc), 32'd2);
        chk("jal_bal", 32'(bus.BranchAlways), 32'd1);
        chk("jal_ra", 32'(bus.RaddrA), 32'd2);
        step(1'b1, 9'b0_0011_0000, 1'b0);
        chk("nxt0_op", 32'(bus.ALU_OP), 32'(INC));
        chk("nxt0_wa", 32'(bus.Waddr), 32'd8);
        step(1'b1, 9'b0_0011_0101, 1'b0);
        chk("nxt5_op", 32'(bus.ALU_OP), 32'(DEC));
        chk("nxt5_ra", 32'(bus.RaddrA), 32'd13);

        // flush drops SUB
        step(1'b1, 9'b0_0100_0001, 1'b0);
        step(1'b1, 9'b0_0101_0010, 1'b1);
        chk("flush_valid", 32'(bus.ctrl_valid), 32'd0);
        step(1'b0, 9'b0, 1'b0);

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            ri = 9'($urandom_range(0, 511));
            if (ri[8:4] == 5'b0_1011) ri[4] = 1'b0;
            step($urandom_range(0, 9) < 7, ri, $urandom_range(0, 9) == 0);
        end
        step(1'b0, 9'b0, 1'b0);

        // reset in the middle of a load wait
        step(1'b1, 9'b0_0010_0110, 1'b0);
        chk("lw_before_reset", 32'(bus.instr_ready), 32'd0);
        do_reset();

        // DNE: sticky halt under continuous valid and flush
        step(1'b1, 9'b0_1011_0000, 1'b0);
        chk("dne_done", 32'(bus.Done), 32'd1);
        chk("dne_valid", 32'(bus.ctrl_valid), 32'd0);
        for (int n = 0; n < 4; n++) begin
            step(1'b1, 9'b0_0100_0011, n == 2);
            chk("halt_ready", 32'(bus.instr_ready), 32'd0);
            chk("halt_done", 32'(bus.Done), 32'd1);
        end
        do_reset();

        step(1'b1, 9'b0_0100_0101, 1'b0);
        chk("post_reset_valid", 32'(bus.ctrl_valid), 32'd1);
        step(1'b0, 9'b0, 1'b0);
        step(1'b0, 9'b0, 1'b0);
        chk("queue_drained", 32'(e_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
